// File: rtl/png_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : png_pkg
//  Description : Shared types and constants for the PNG scanline filter:
//                FSM state encoding, filter-type bytes, picture-size widths
//                and the row-length helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package png_pkg;

    localparam int PIC_DIM_W  = 11;
    localparam int BYTE_CNT_W = 13;

    localparam logic [7:0] PNG_FILT_NONE = 8'h00;
    localparam logic [7:0] PNG_FILT_SUB  = 8'h01;

    typedef enum logic [1:0] {
        ST_HDR = 2'd0,
        ST_ROW = 2'd1,
        ST_END = 2'd2
    } png_state_e;

    // Bytes per row = 3 * width, built as (w<<1)+w; 13 bits never overflow (max 6141).
    function automatic logic [BYTE_CNT_W-1:0] row_bytes(input logic [PIC_DIM_W-1:0] w);
        logic [BYTE_CNT_W-1:0] w_ext;
        w_ext     = {2'b00, w};
        row_bytes = (w_ext << 1) + w_ext;
    endfunction

endpackage
`default_nettype wire

// File: rtl/png_sub_unit.sv
`default_nettype none
// ============================================================================
//  Module      : png_sub_unit
//  Description : PNG Sub filter datapath. Keeps the last three raw bytes of
//                the current row and outputs data_i minus the byte three
//                positions earlier (mod 256). History is zero after clr_i,
//                so the first pixel of a row passes unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module png_sub_unit (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    output logic [7:0] diff_o
);

    logic [7:0] hist_q [3];

    // Three-deep raw-byte history: cleared at each row header, shifted per accepted byte.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist_q[0] <= 8'h00;
            hist_q[1] <= 8'h00;
            hist_q[2] <= 8'h00;
        end else if (clr_i) begin
            hist_q[0] <= 8'h00;
            hist_q[1] <= 8'h00;
            hist_q[2] <= 8'h00;
        end else if (en_i) begin
            hist_q[0] <= data_i;
            hist_q[1] <= hist_q[0];
            hist_q[2] <= hist_q[1];
        end
    end

    assign diff_o = data_i - hist_q[2];

endmodule
`default_nettype wire

// File: rtl/png_scanline_filter.sv
`default_nettype none
// ============================================================================
//  Module      : png_scanline_filter
//  Description : Converts a serial R,G,B byte stream into PNG raw scanlines:
//                each row of 3*pic_width bytes is prefixed by a filter-type
//                byte. Output is a single registered byte slot with
//                valid/ready handshake. frame_err flags a disagreement
//                between pixel_in_done and the internal end-of-frame count.
//                Build option: define PNG_FILTER_SUB_EN to select the Sub
//                filter (header 8'h01); otherwise filter None (8'h00).
//  Revision    : 1.0 - initial release
// ============================================================================
import png_pkg::*;

module png_scanline_filter (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [PIC_DIM_W-1:0] pic_width,
    input  logic [PIC_DIM_W-1:0] pic_height,
    input  logic [7:0]           pixel_in_data,
    input  logic                 pixel_in_valid,
    input  logic                 pixel_in_done,
    output logic                 pixel_in_rdy,
    output logic [7:0]           fdata_out,
    output logic                 fdata_valid,
    output logic                 fdata_last,
    input  logic                 fdata_rdy,
    output logic                 frame_err
);

    png_state_e              state_q, state_d;
    logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [PIC_DIM_W-1:0]    row_cnt_q, row_cnt_d;
    logic [7:0]              fdata_out_q, fdata_out_d;
    logic                    fdata_valid_q, fdata_valid_d;
    logic                    fdata_last_q, fdata_last_d;
    logic                    frame_err_q, frame_err_d;

    logic                    slot_free;
    logic                    row_end;
    logic                    row_last;
    logic                    frame_end;
    logic                    accept;
    logic                    hist_clr;
    logic [7:0]              filt_byte;
    logic [7:0]              hdr_byte;

    assign slot_free = ~fdata_valid_q | fdata_rdy;
    assign row_end   = (byte_cnt_q == row_bytes(pic_width) - 13'd1);
    assign row_last  = (row_cnt_q == pic_height - 11'd1);
    assign frame_end = row_end & row_last;

`ifdef PNG_FILTER_SUB_EN
    assign hdr_byte = PNG_FILT_SUB;

    png_sub_unit u_sub (
        .clk    (clk),
        .rstn   (rstn),
        .clr_i  (hist_clr),
        .en_i   (accept),
        .data_i (pixel_in_data),
        .diff_o (filt_byte)
    );
`else
    assign hdr_byte  = PNG_FILT_NONE;
    assign filt_byte = pixel_in_data;
`endif

    // Next-state, slot loading and handshake decode for the header/row/end sequencer.
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        row_cnt_d     = row_cnt_q;
        fdata_out_d   = fdata_out_q;
        fdata_valid_d = fdata_valid_q;
        fdata_last_d  = fdata_last_q;
        frame_err_d   = frame_err_q;
        pixel_in_rdy  = 1'b0;
        accept        = 1'b0;
        hist_clr      = 1'b0;

        // A consumed (or empty) slot drains unless reloaded below.
        if (slot_free) begin
            fdata_valid_d = 1'b0;
            fdata_last_d  = 1'b0;
        end

        case (state_q)
            ST_HDR: begin
                // Header is emitted only once the first byte of the row is waiting.
                if (pixel_in_valid && slot_free) begin
                    fdata_out_d   = hdr_byte;
                    fdata_valid_d = 1'b1;
                    fdata_last_d  = 1'b0;
                    byte_cnt_d    = '0;
                    hist_clr      = 1'b1;
                    state_d       = ST_ROW;
                end
            end
            ST_ROW: begin
                pixel_in_rdy = slot_free;
                accept       = pixel_in_valid & slot_free;
                if (accept) begin
                    fdata_out_d   = filt_byte;
                    fdata_valid_d = 1'b1;
                    fdata_last_d  = frame_end;
                    if (pixel_in_done != frame_end) begin
                        frame_err_d = 1'b1;
                    end
                    if (row_end) begin
                        byte_cnt_d = '0;
                        if (row_last) begin
                            state_d = ST_END;
                        end else begin
                            row_cnt_d = row_cnt_q + 11'd1;
                            state_d   = ST_HDR;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 13'd1;
                    end
                end
            end
            ST_END: begin
                // Wait for the final byte to leave before starting the next frame.
                if (fdata_valid_q && fdata_rdy) begin
                    row_cnt_d = '0;
                    state_d   = ST_HDR;
                end
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase
    end

    // State, counters, output slot and sticky error register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_HDR;
            byte_cnt_q    <= '0;
            row_cnt_q     <= '0;
            fdata_out_q   <= 8'h00;
            fdata_valid_q <= 1'b0;
            fdata_last_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            row_cnt_q     <= row_cnt_d;
            fdata_out_q   <= fdata_out_d;
            fdata_valid_q <= fdata_valid_d;
            fdata_last_q  <= fdata_last_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign fdata_out   = fdata_out_q;
    assign fdata_valid = fdata_valid_q;
    assign fdata_last  = fdata_last_q;
    assign frame_err   = frame_err_q;

endmodule
`default_nettype wire
